// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel front end for asynchronous board inputs (buttons, switches).
// Each channel has its own synchroniser, a counter-based debounce FSM,
// single-cycle rise/fall strobes and, optionally, hold-to-repeat strobes.
//
// Optional feature macro: INPUT_CONDITIONER_AUTO_REPEAT_EN
//   defined   : per-channel repeat counter drives rpt while the level is high
//   undefined : rpt is tied to 0 and no repeat logic is built
//
// Parameters:
//   CHANNELS        number of independent channels (>=1)
//   SYNC_STAGES     synchroniser depth (>=2)
//   DEBOUNCE_CYCLES stable synced cycles needed to accept a change (>=1)
//   REPEAT_DELAY    cycles from rise strobe to first rpt strobe (>=1)
//   REPEAT_PERIOD   cycles between subsequent rpt strobes (>=1)
//
// Ports:
//   clk    in  1         system clock (clk_mac)
//   rst_n  in  1         asynchronous active-low reset
//   in     in  CHANNELS  raw asynchronous inputs
//   out    out CHANNELS  debounced level
//   rise   out CHANNELS  1-cycle strobe when out goes 0->1
//   fall   out CHANNELS  1-cycle strobe when out goes 1->0
//   rpt    out CHANNELS  1-cycle auto-repeat strobe
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int CHANNELS        = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_PEND_LO = 2'd3
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;

        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   r_out;
        logic                   w_out_nxt;
        logic                   r_rise;
        logic                   w_rise_nxt;
        logic                   r_fall;
        logic                   w_fall_nxt;

        // Synchroniser: bit 0 samples the pin, last bit is the synced level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], in[g]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_LO;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        // Pending states count consecutive cycles at the new level; any
        // return to the old level abandons the change and clears the count.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_out_nxt   = r_out;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            case (r_state)
                ST_LO: begin
                    if (w_s) begin
                        w_state_nxt = ST_PEND_HI;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_PEND_HI: begin
                    if (!w_s) begin
                        w_state_nxt = ST_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_C) begin
                        w_state_nxt = ST_HI;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!w_s) begin
                        w_state_nxt = ST_PEND_LO;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_PEND_LO: begin
                    if (w_s) begin
                        w_state_nxt = ST_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_C) begin
                        w_state_nxt = ST_LO;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                end
            endcase
        end

        assign out[g]  = r_out;
        assign rise[g] = r_rise;
        assign fall[g] = r_fall;

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
        localparam logic [CNT_W-1:0] RD_C = CNT_W'(REPEAT_DELAY);
        localparam logic [CNT_W-1:0] RP_C = CNT_W'(REPEAT_PERIOD);

        logic [CNT_W-1:0] r_rcnt;
        logic             r_rperiodic;  // 0: waiting REPEAT_DELAY, 1: REPEAT_PERIOD
        logic             r_rpt;
        logic [CNT_W-1:0] w_rcnt_inc;
        logic [CNT_W-1:0] w_rtarget;

        assign w_rcnt_inc = r_rcnt + CNT_W'(1);
        assign w_rtarget  = r_rperiodic ? RP_C : RD_C;

        // The counter restarts on the rise strobe and is held clear whenever
        // the channel is (or is becoming) LO, so the LO-entry edge never
        // emits a repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rcnt      <= '0;
                r_rperiodic <= 1'b0;
                r_rpt       <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (w_rise_nxt || (w_state_nxt == ST_LO)) begin
                    r_rcnt      <= '0;
                    r_rperiodic <= 1'b0;
                end else if ((r_state == ST_HI) || (r_state == ST_PEND_LO)) begin
                    if (w_rcnt_inc == w_rtarget) begin
                        r_rpt       <= 1'b1;
                        r_rcnt      <= '0;
                        r_rperiodic <= 1'b1;
                    end else begin
                        r_rcnt      <= w_rcnt_inc;
                    end
                end
            end
        end

        assign rpt[g] = r_rpt;
`else
        assign rpt[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed, table-driven bench for input_conditioner. Main instance uses
// CHANNELS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_PERIOD=5; a second instance uses DEBOUNCE_CYCLES=1.
// Edge n counts rising edges after the inputs are driven (edge 1 is the first
// edge that samples the new level); outputs are checked 1 time unit after
// each edge.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in;
    logic [2:0] out;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] rpt;
    logic [2:0] in1;
    logic [2:0] out1;
    logic [2:0] rise1;
    logic [2:0] fall1;
    logic [2:0] rpt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .CHANNELS       (3),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in),
        .out  (out),
        .rise (rise),
        .fall (fall),
        .rpt  (rpt)
    );

    input_conditioner #(
        .CHANNELS       (3),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in1),
        .out  (out1),
        .rise (rise1),
        .fall (fall1),
        .rpt  (rpt1)
    );

    // Input is high on sample bit b when b lies in [s1,s1+l1) or [s2,s2+l2).
    // rise_at/fall_at are the edge numbers of the strobes (0 = none in window).
    typedef struct {
        string      name;
        logic [2:0] mask;
        int         s1;
        int         l1;
        int         s2;
        int         l2;
        int         rise_at;
        int         fall_at;
        int         window;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reset both instances; outputs must be clear while rst_n is low.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        in    = '0;
        in1   = '0;
        #12;
        chk({tag, "_rst_main"}, {20'd0, out, rise, fall, rpt}, 32'd0);
        chk({tag, "_rst_db1"},  {20'd0, out1, rise1, fall1, rpt1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic exp_rpt(input int n, input int r, input int f);
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
        if (r == 0 || n <= r) return 1'b0;
        if (f != 0 && n >= f) return 1'b0;
        if ((n - r) < 20) return 1'b0;
        return ((n - r - 20) % 5) == 0;
`else
        return 1'b0 & (n > r) & (f >= 0);
`endif
    endfunction

    initial begin
        rst_n = 1'b0;
        in    = '0;
        in1   = '0;

        //            name           mask    s1 l1  s2 l2 rise fall win
        vecs[0] = '{"clean_ch0",   3'b001, 0, 30, 0,  0, 11, 41,  60};
        vecs[1] = '{"glitch_ch1",  3'b010, 0, 7,  8,  7, 0,  0,   40};
        vecs[2] = '{"simul_all",   3'b111, 0, 30, 0,  0, 11, 41,  60};
        vecs[3] = '{"width8_rej",  3'b100, 0, 8,  0,  0, 0,  0,   30};
        vecs[4] = '{"width9_acc",  3'b100, 0, 9,  0,  0, 11, 20,  40};
        vecs[5] = '{"fall_glitch", 3'b001, 0, 30, 37, 30, 11, 0,  70};
        vecs[6] = '{"hold_rpt",    3'b001, 0, 71, 0,  0, 11, 82, 100};

        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].name);
            for (int n = 1; n <= vecs[v].window; n++) begin
                int         b;
                logic       hi;
                logic       e_out;
                logic       e_rise;
                logic       e_fall;
                logic       e_rpt;
                logic [2:0] m;
                b  = n - 1;
                hi = ((b >= vecs[v].s1) && (b < vecs[v].s1 + vecs[v].l1)) ||
                     ((vecs[v].l2 > 0) && (b >= vecs[v].s2) && (b < vecs[v].s2 + vecs[v].l2));
                m  = vecs[v].mask;
                in = hi ? m : 3'b000;
                @(posedge clk);
                #1;
                e_out  = (vecs[v].rise_at != 0) && (n >= vecs[v].rise_at) &&
                         ((vecs[v].fall_at == 0) || (n < vecs[v].fall_at));
                e_rise = (vecs[v].rise_at != 0) && (n == vecs[v].rise_at);
                e_fall = (vecs[v].fall_at != 0) && (n == vecs[v].fall_at);
                e_rpt  = exp_rpt(n, vecs[v].rise_at, vecs[v].fall_at);
                chk($sformatf("%s_e%0d", vecs[v].name, n),
                    {20'd0, out, rise, fall, rpt},
                    {20'd0, m & {3{e_out}}, m & {3{e_rise}}, m & {3{e_fall}}, m & {3{e_rpt}}});
            end
        end

        // Asynchronous reset clears an accepted high level mid-cycle.
        do_reset("async");
        in = 3'b001;
        repeat (11) @(posedge clk);
        #1;
        chk("async_pre", {26'd0, out, rise}, {26'd0, 3'b001, 3'b001});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_during", {20'd0, out, rise, fall, rpt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the 5th debounce cycle loses the pending press; with in
        // still high it is re-qualified from scratch after release.
        do_reset("middeb");
        in = 3'b001;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("middeb_low", {20'd0, out, rise, fall, rpt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            chk($sformatf("middeb_e%0d", n), {26'd0, out, rise},
                {26'd0, (n >= 11) ? 3'b001 : 3'b000, (n == 11) ? 3'b001 : 3'b000});
        end

        // DEBOUNCE_CYCLES=1: a one-sample pulse is rejected.
        do_reset("db1_w1");
        for (int n = 1; n <= 8; n++) begin
            in1 = (n == 1) ? 3'b001 : 3'b000;
            @(posedge clk);
            #1;
            chk($sformatf("db1_w1_e%0d", n), {23'd0, out1, rise1, fall1}, 32'd0);
        end

        // DEBOUNCE_CYCLES=1: a two-sample pulse rises at edge 4, falls at 6.
        do_reset("db1_w2");
        for (int n = 1; n <= 10; n++) begin
            in1 = (n <= 2) ? 3'b001 : 3'b000;
            @(posedge clk);
            #1;
            chk($sformatf("db1_w2_e%0d", n), {23'd0, out1, rise1, fall1},
                {23'd0, (n == 4 || n == 5) ? 3'b001 : 3'b000,
                        (n == 4) ? 3'b001 : 3'b000,
                        (n == 6) ? 3'b001 : 3'b000});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised multi-channel front end for asynchronous board inputs such as buttons and switches. It generalises the single-bit debounce instances currently used for btnc/btnu/btnd. Per channel it provides:
- a synchroniser of configurable depth
- a counter-based debounce state machine
- single-cycle rise and fall strobes
- optional hold-to-repeat strobes

It sits between the board pins and eth_mac control inputs, clocked by clk_mac.

Parameters:
CHANNELS, 3, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable synced cycles required to accept a level change (>=1; 10 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from press acceptance to first repeat strobe (>=1; used only with macro)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (>=1; used only with macro)

Ports:
clk  in  1  system clock (clk_mac)
rst_n  in  1  asynchronous active-low reset
in  in  CHANNELS  raw asynchronous inputs
out  out  CHANNELS  debounced level
rise  out  CHANNELS  1-cycle strobe when out goes 0->1
fall  out  CHANNELS  1-cycle strobe when out goes 1->0
rpt  out  CHANNELS  1-cycle auto-repeat strobe

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert; all flops clear while it is low.
- Reset values: synchroniser 0, out 0, rise 0, fall 0, rpt 0, all counters 0, all FSMs in LO.
- Channel independence: channels are fully independent. Each has its own synchroniser, counter and FSM.
- Synchroniser: SYNC_STAGES-deep flop chain. Its last stage is "s".
- FSM states per channel:
  - LO: out=0. If s=1, go to PEND_HI with cnt=1; else stay.
  - PEND_HI: if s=0, go to LO and clear cnt (glitch rejected). Else if cnt==DEBOUNCE_CYCLES, go to HI, set out=1, pulse rise, clear cnt. Else cnt++.
  - HI: mirror of LO, with s=0 going to PEND_LO.
  - PEND_LO: mirror of PEND_HI. On completion go to LO, set out=0, pulse fall.
- DEBOUNCE_CYCLES=1 is legal and follows the same rule; no special-casing.
- Latency: out changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples in at the new level, provided in stays stable.
  - rise/fall assert in the same cycle out changes, for exactly one cycle.
- Glitch rejection: any excursion that leaves s at the new level for fewer than DEBOUNCE_CYCLES consecutive cycles produces no change on out/rise/fall. The counter restarts from the beginning on each new excursion.
- Counter width: $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1). The counter never wraps; it is always cleared before reaching its maximum.
- Reset mid-debounce: the pending change is lost. If in is still high after rst_n rises, the press is re-qualified from LO and produces a normal rise strobe after full latency.
- Strobe exclusivity: rise and fall are never asserted together on the same channel.
- Simultaneous changes: changes on multiple channels in the same cycle are handled independently. Multiple strobes in one cycle are legal.

Optional Feature:
Macro INPUT_CONDITIONER_AUTO_REPEAT_EN.

Defined:
- Each channel has a repeat counter that runs only while in HI or PEND_LO.
- The counter clears on the rise strobe.
- rpt pulses one cycle when REPEAT_DELAY cycles have elapsed after the rise strobe, then every REPEAT_PERIOD cycles thereafter.
- On entry to LO the repeat counter clears and no further rpt is issued.
- rpt never coincides with rise.

Undefined:
- rpt is tied to 0.
- No repeat counters are synthesised; REPEAT_* parameters are ignored.

Test Plan:
Bench parameters for all scenarios: CHANNELS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
1. Clean press/release: in[0] 0->1, held 30 cycles, then ->0.
   - out[0] rises 10 edges after first sample, with rise[0] for 1 cycle.
   - out[0] falls 10 edges after the release sample, with fall[0] for 1 cycle.
   - Channels 1 and 2 stay 0.
2. Glitch rejection: in[1] high for 7 cycles, low for 1, high for 7, then low.
   - out[1], rise[1] and fall[1] stay 0 throughout.
3. Simultaneous channels: in[2:0] 000->111 on one edge.
   - rise=111 in a single cycle, 10 edges later.
4. Reset mid-operation: in[0]=1, pulse rst_n low at cycle 5 of debounce, keep in[0]=1.
   - Outputs are 0 asynchronously during reset.
   - out[0] rises 10 edges after the first post-reset sample.
5. Auto-repeat, macro defined: hold in[0] high 60 cycles after the rise strobe.
   - rpt[0] pulses at +20, +25, +30 … +55 cycles after rise.
   - No rpt after fall[0].
   - Macro undefined: rpt stays 0 for the same stimulus.
6. DEBOUNCE_CYCLES=1 variant: single-cycle-wide high input.
   - Not accepted, because it needs 1 stable synced cycle plus the transition.
   - 2-cycle-wide input gives rise exactly 3 edges after the first sample.
